// File: rtl/life_pkg.sv
// Shared definitions for the 16x16 life grid: dimensions, scanner states and
// the cell-index layout used by both the core and the display back-end.
package life_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int CELLS  = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } scan_state_t;

    // Row-major layout: bit y*16+x holds cell (x,y).
    function automatic logic [7:0] idx(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/matrix_scanner_scan_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded interval
// (load N-1 for an N-cycle interval).
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/matrix_scanner.sv
// Scans a snapshot of the life grid onto a 16x16 LED matrix through a serial
// shift-register chain, one row at a time, with a blinking cursor overlay.
module matrix_scanner
    import life_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int ROW_HOLD     = 2000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] map,
    input  logic [3:0]   cursor_x,
    input  logic [3:0]   cursor_y,
    input  logic         cursor_en,
    output logic         sr_data,
    output logic         sr_clk,
    output logic         sr_latch,
    output logic [3:0]   row_sel,
    output logic         row_en,
    output logic         frame_done
);

    localparam int MAX_PHASE = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
    localparam int TW        = $clog2(MAX_PHASE + 1);
    localparam int BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TW-1:0] DIV_LOAD   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(ROW_HOLD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    scan_state_t state_reg, state_next;
    logic        phase_hi_reg, phase_hi_next;
    logic [3:0]  r_reg, r_next;
    logic [3:0]  c_reg, c_next;

    logic [255:0] snap_map_reg;
    logic [3:0]   snap_cx_reg, snap_cy_reg;
    logic         snap_en_reg;

    logic          blink_phase_reg, blink_phase_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;

    logic       sr_data_reg, sr_data_next;
    logic       sr_clk_reg, sr_clk_next;
    logic       sr_latch_reg, sr_latch_next;
    logic [3:0] row_sel_reg, row_sel_next;
    logic       row_en_reg, row_en_next;
    logic       frame_done_reg, frame_done_next;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    logic [3:0] r_inc, c_dec;
    assign r_inc = r_reg + 4'd1;
    assign c_dec = c_reg - 4'd1;

    // In LOAD the snapshot is being captured on this very edge, so the first
    // pixel must come straight from the live inputs.
    logic [255:0] view_map;
    logic [3:0]   view_cx, view_cy;
    logic         view_en;
    assign view_map = (state_reg == LOAD) ? map       : snap_map_reg;
    assign view_cx  = (state_reg == LOAD) ? cursor_x  : snap_cx_reg;
    assign view_cy  = (state_reg == LOAD) ? cursor_y  : snap_cy_reg;
    assign view_en  = (state_reg == LOAD) ? cursor_en : snap_en_reg;

    function automatic logic pixel_of(
        input logic [255:0] m,
        input logic [3:0]   cx,
        input logic [3:0]   cy,
        input logic         en,
        input logic         blink,
        input logic [3:0]   r,
        input logic [3:0]   c
    );
        return m[idx(c, r)] ^ (en & blink & (r == cy) & (c == cx));
    endfunction

    scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_next       = state_reg;
        phase_hi_next    = phase_hi_reg;
        r_next           = r_reg;
        c_next           = c_reg;
        blink_phase_next = blink_phase_reg;
        blink_cnt_next   = blink_cnt_reg;
        sr_data_next     = sr_data_reg;
        sr_clk_next      = sr_clk_reg;
        sr_latch_next    = sr_latch_reg;
        row_sel_next     = row_sel_reg;
        row_en_next      = row_en_reg;
        frame_done_next  = 1'b0;
        timer_load       = 1'b0;
        timer_val        = DIV_LOAD;

        case (state_reg)
            LOAD: begin
                state_next    = SHIFT;
                phase_hi_next = 1'b0;
                r_next        = 4'd0;
                c_next        = 4'd15;
                timer_load    = 1'b1;
                sr_clk_next   = 1'b0;
                sr_latch_next = 1'b0;
                row_en_next   = 1'b0;
                sr_data_next  = pixel_of(view_map, view_cx, view_cy, view_en,
                                         blink_phase_reg, 4'd0, 4'd15);
            end
            SHIFT: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (!phase_hi_reg) begin
                        phase_hi_next = 1'b1;
                        sr_clk_next   = 1'b1;
                    end else if (c_reg == 4'd0) begin
                        state_next    = LATCH;
                        sr_clk_next   = 1'b0;
                        sr_latch_next = 1'b1;
                        row_sel_next  = r_reg;
                    end else begin
                        // Data only moves together with the falling shift clock.
                        c_next        = c_dec;
                        phase_hi_next = 1'b0;
                        sr_clk_next   = 1'b0;
                        sr_data_next  = pixel_of(view_map, view_cx, view_cy, view_en,
                                                 blink_phase_reg, r_reg, c_dec);
                    end
                end
            end
            LATCH: begin
                if (timer_done) begin
                    state_next    = HOLD;
                    sr_latch_next = 1'b0;
                    row_en_next   = 1'b1;
                    timer_load    = 1'b1;
                    timer_val     = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (timer_done) begin
                    row_en_next = 1'b0;
                    if (r_reg == 4'd15) begin
                        state_next      = LOAD;
                        frame_done_next = 1'b1;
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_next   = '0;
                            blink_phase_next = ~blink_phase_reg;
                        end else begin
                            blink_cnt_next = blink_cnt_reg + 1'b1;
                        end
                    end else begin
                        state_next    = SHIFT;
                        r_next        = r_inc;
                        c_next        = 4'd15;
                        phase_hi_next = 1'b0;
                        sr_clk_next   = 1'b0;
                        timer_load    = 1'b1;
                        sr_data_next  = pixel_of(view_map, view_cx, view_cy, view_en,
                                                 blink_phase_reg, r_inc, 4'd15);
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= LOAD;
            phase_hi_reg    <= 1'b0;
            r_reg           <= 4'd0;
            c_reg           <= 4'd15;
            blink_phase_reg <= 1'b0;
            blink_cnt_reg   <= '0;
            sr_data_reg     <= 1'b0;
            sr_clk_reg      <= 1'b0;
            sr_latch_reg    <= 1'b0;
            row_sel_reg     <= 4'd0;
            row_en_reg      <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_hi_reg    <= phase_hi_next;
            r_reg           <= r_next;
            c_reg           <= c_next;
            blink_phase_reg <= blink_phase_next;
            blink_cnt_reg   <= blink_cnt_next;
            sr_data_reg     <= sr_data_next;
            sr_clk_reg      <= sr_clk_next;
            sr_latch_reg    <= sr_latch_next;
            row_sel_reg     <= row_sel_next;
            row_en_reg      <= row_en_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    // Frozen for a whole frame so a mid-frame map update cannot tear the image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_map_reg <= '0;
            snap_cx_reg  <= 4'd0;
            snap_cy_reg  <= 4'd0;
            snap_en_reg  <= 1'b0;
        end else if (state_reg == LOAD) begin
            snap_map_reg <= map;
            snap_cx_reg  <= cursor_x;
            snap_cy_reg  <= cursor_y;
            snap_en_reg  <= cursor_en;
        end
    end

    assign sr_data    = sr_data_reg;
    assign sr_clk     = sr_clk_reg;
    assign sr_latch   = sr_latch_reg;
    assign row_sel    = row_sel_reg;
    assign row_en     = row_en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed bench for matrix_scanner: models the external 16-stage shift chain
// and checks latched rows, frame timing, blanking, blinking and async reset.
module tb_matrix_scanner;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] map = '0;
    logic [3:0]   cursor_x = 4'd0;
    logic [3:0]   cursor_y = 4'd0;
    logic         cursor_en = 1'b0;
    logic         sr_data, sr_clk, sr_latch, row_en, frame_done;
    logic [3:0]   row_sel;

    int pass_cnt = 0;
    int total_cnt = 0;

    matrix_scanner #(.CLK_DIV(1), .ROW_HOLD(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .map        (map),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .cursor_en  (cursor_en),
        .sr_data    (sr_data),
        .sr_clk     (sr_clk),
        .sr_latch   (sr_latch),
        .row_sel    (row_sel),
        .row_en     (row_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // External chain model and per-frame activity counters.
    logic [15:0] shreg = '0;
    logic [15:0] rows [16];
    logic        prev_clk = 1'b0;
    logic        prev_latch = 1'b0;
    logic [3:0]  last_latched = 4'd0;
    int latch_pulses, latch_cycles, hold_cycles, blank_err, rowsel_err, first_latch_row;

    always @(negedge clk) begin
        if (rst) begin
            prev_clk   = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (sr_clk && !prev_clk) shreg = {shreg[14:0], sr_data};
            if (sr_latch && !prev_latch) begin
                rows[row_sel] = shreg;
                last_latched  = row_sel;
                latch_pulses++;
                if (first_latch_row < 0) first_latch_row = int'(row_sel);
            end
            if (sr_latch) latch_cycles++;
            if (row_en) begin
                hold_cycles++;
                if (sr_latch || sr_clk || (sr_clk != prev_clk)) blank_err++;
                if (row_sel != last_latched) rowsel_err++;
            end
            prev_clk   = sr_clk;
            prev_latch = sr_latch;
        end
    end

    task automatic clear_capture();
        for (int i = 0; i < 16; i++) rows[i] = 16'hDEAD;
        latch_pulses = 0; latch_cycles = 0; hold_cycles = 0;
        blank_err = 0; rowsel_err = 0; first_latch_row = -1;
    endtask

    // Returns the number of rising edges until frame_done is seen, -1 on timeout.
    task automatic wait_frame(output int n);
        n = -1;
        for (int k = 1; k <= 700; k++) begin
            @(posedge clk); #1;
            if (frame_done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
    endtask

    task automatic test_reset();
        int n;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if ({sr_data, sr_clk, sr_latch, row_en, frame_done} !== 5'b0) $display("FAIL reset_ctl got=%b exp=00000", {sr_data, sr_clk, sr_latch, row_en, frame_done}); else pass_cnt++;
        total_cnt++; if (row_sel !== 4'd0) $display("FAIL reset_row_sel got=%0d exp=0", row_sel); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
        wait_frame(n);
        total_cnt++; if (n !== 593) $display("FAIL first_frame_done got=%0d exp=593", n); else pass_cnt++;
        wait_frame(n);
        total_cnt++; if (n !== 593) $display("FAIL frame_period got=%0d exp=593", n); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL frame_done_width got=%b exp=0", frame_done); else pass_cnt++;
    endtask

    task automatic test_glider();
        int n;
        logic [15:0] exp;
        map = '0;
        map[0] = 1'b1; map[17] = 1'b1; map[18] = 1'b1; map[32] = 1'b1; map[33] = 1'b1;
        cursor_en = 1'b0;
        do_reset();
        wait_frame(n);
        total_cnt++; if (n !== 593) $display("FAIL glider_frame got=%0d exp=593", n); else pass_cnt++;
        for (int r = 0; r < 16; r++) begin
            exp = (r == 0) ? 16'h0001 : (r == 1) ? 16'h0006 : (r == 2) ? 16'h0003 : 16'h0000;
            total_cnt++; if (rows[r] !== exp) $display("FAIL glider_row%0d got=%h exp=%h", r, rows[r], exp); else pass_cnt++;
        end
        total_cnt++; if (rowsel_err !== 0) $display("FAIL glider_row_sel errors=%0d exp=0", rowsel_err); else pass_cnt++;
    endtask

    task automatic test_anti_tearing();
        int n;
        logic [15:0] exp;
        clear_capture();
        repeat (276) @(posedge clk);
        map = '1;
        wait_frame(n);
        total_cnt++; if (n !== 317) $display("FAIL tear_remaining got=%0d exp=317", n); else pass_cnt++;
        for (int r = 0; r < 16; r++) begin
            exp = (r == 0) ? 16'h0001 : (r == 1) ? 16'h0006 : (r == 2) ? 16'h0003 : 16'h0000;
            total_cnt++; if (rows[r] !== exp) $display("FAIL tear_old_row%0d got=%h exp=%h", r, rows[r], exp); else pass_cnt++;
        end
        clear_capture();
        wait_frame(n);
        for (int r = 0; r < 16; r++) begin
            total_cnt++; if (rows[r] !== 16'hFFFF) $display("FAIL tear_new_row%0d got=%h exp=ffff", r, rows[r]); else pass_cnt++;
        end
    endtask

    task automatic test_cursor_blink();
        int n;
        logic [15:0] exp, others;
        map = '0;
        cursor_x = 4'd5; cursor_y = 4'd9; cursor_en = 1'b1;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            wait_frame(n);
            exp = (((f / 2) % 2) == 1) ? 16'h0020 : 16'h0000;
            others = '0;
            for (int r = 0; r < 16; r++) if (r != 9) others |= rows[r];
            total_cnt++; if (rows[9] !== exp) $display("FAIL blink_f%0d_row9 got=%h exp=%h", f, rows[9], exp); else pass_cnt++;
            total_cnt++; if (others !== 16'h0000) $display("FAIL blink_f%0d_others got=%h exp=0000", f, others); else pass_cnt++;
            clear_capture();
        end
    endtask

    task automatic test_blanking();
        int n;
        wait_frame(n);
        total_cnt++; if (n !== 593) $display("FAIL blank_frame got=%0d exp=593", n); else pass_cnt++;
        total_cnt++; if (hold_cycles !== 64) $display("FAIL blank_hold_cycles got=%0d exp=64", hold_cycles); else pass_cnt++;
        total_cnt++; if (blank_err !== 0) $display("FAIL blank_overlap got=%0d exp=0", blank_err); else pass_cnt++;
        total_cnt++; if (latch_pulses !== 16) $display("FAIL blank_latch_pulses got=%0d exp=16", latch_pulses); else pass_cnt++;
        total_cnt++; if (latch_cycles !== 16) $display("FAIL blank_latch_cycles got=%0d exp=16", latch_cycles); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int n;
        logic [3:0] sel_before;
        cursor_en = 1'b0;
        map = '1;
        wait_frame(n);
        repeat (381) @(posedge clk);
        #2;
        sel_before = row_sel;
        total_cnt++; if (sel_before !== 4'd9) $display("FAIL areset_pre_row got=%0d exp=9", sel_before); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if ({sr_data, sr_clk, sr_latch, row_en, frame_done} !== 5'b0) $display("FAIL areset_ctl got=%b exp=00000", {sr_data, sr_clk, sr_latch, row_en, frame_done}); else pass_cnt++;
        total_cnt++; if (row_sel !== 4'd0) $display("FAIL areset_row_sel got=%0d exp=0", row_sel); else pass_cnt++;
        map = '0;
        map[3] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_capture();
        wait_frame(n);
        total_cnt++; if (n !== 593) $display("FAIL areset_frame got=%0d exp=593", n); else pass_cnt++;
        total_cnt++; if (first_latch_row !== 0) $display("FAIL areset_first_row got=%0d exp=0", first_latch_row); else pass_cnt++;
        total_cnt++; if (rows[0] !== 16'h0008) $display("FAIL areset_snapshot got=%h exp=0008", rows[0]); else pass_cnt++;
        total_cnt++; if (rows[5] !== 16'h0000) $display("FAIL areset_row5 got=%h exp=0000", rows[5]); else pass_cnt++;
    endtask

    initial begin
        clear_capture();
        test_reset();
        test_glider();
        test_anti_tearing();
        test_cursor_blink();
        test_blanking();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
